// File: rtl/mac_sequencer.sv
// Sequencer feeding an 8x8 MAC: clears it, streams N_ELEM operand pairs from a
// synchronous-read memory, drains the 3-stage pipeline and captures the dot product.
module mac_sequencer #(
  parameter int N_ELEM = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_a,
  input  logic [7:0]        mem_b,
  output logic [7:0]        mac_dataa,
  output logic [7:0]        mac_datab,
  output logic              mac_clken,
  output logic              mac_aclr,
  input  logic [16:0]       mac_result,
  output logic [16:0]       result,
  output logic              result_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_CAPTURE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ELEM - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_drain;
  logic              r_dv;
  logic              r_mac_aclr;
  logic [16:0]       r_result;
  logic              r_valid;
  logic              w_busy;

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_next = S_CLEAR;
      end
      S_CLEAR:   w_next = S_ISSUE;
      S_ISSUE:   if (r_addr == LAST_ADDR) w_next = S_DRAIN;
      S_DRAIN:   if (r_drain == 2'd2) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // The address doubles as the ISSUE length counter; it only advances while
  // staying in ISSUE, so it is 0 on entry and falls back to 0 on exit.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_drain    <= '0;
      r_dv       <= 1'b0;
      r_mac_aclr <= 1'b0;
      r_result   <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_addr     <= (r_state == S_ISSUE && w_next == S_ISSUE) ? r_addr + ADDR_W'(1) : '0;
      r_drain    <= (r_state == S_DRAIN) ? r_drain + 2'd1 : '0;
      r_dv       <= (r_state == S_ISSUE);
      r_mac_aclr <= (w_next == S_CLEAR);
      r_valid    <= (r_state == S_CAPTURE);
      if (r_state == S_CAPTURE) r_result <= mac_result;
    end
  end

  assign busy         = w_busy;
  assign mac_clken    = w_busy;
  assign mem_addr     = r_addr;
  assign mac_aclr     = r_mac_aclr;
  assign mac_dataa    = r_dv ? mem_a : '0;
  assign mac_datab    = r_dv ? mem_b : '0;
  assign result       = r_result;
  assign result_valid = r_valid;

endmodule
